// File: rtl/adc_capture_ctrl_if.sv
// Sample strobe in and capture-RAM write bus out for adc_capture_ctrl.
// master drives samples and receives writes; slave is the controller.
interface adc_capture_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              ad_valid;
  logic [DATA_W-1:0] ad_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output ad_valid,
    output ad_data,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  ad_valid,
    input  ad_data,
    output wr_en,
    output wr_addr,
    output wr_data
  );
endinterface

// File: rtl/adc_capture_ctrl.sv
// Pre/post-trigger ADC capture sequencer into a circular sample RAM.
// Optional AUTO_TRIG_EN forces a trigger after AUTO_TIMEOUT idle strobes.
module adc_capture_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
`ifdef AUTO_TRIG_EN
  ,
  parameter int AUTO_TIMEOUT = 65535
`endif
) (
  input  logic              I_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  adc_capture_ctrl_if.slave bus,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_rise,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic [ADDR_W-1:0] post_len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr
`ifdef AUTO_TRIG_EN
  ,
  output logic              auto_trig
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WAIT_TRIG,
    POST,
    DONE
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] lvl;
  logic              rise;
  logic [ADDR_W-1:0] pre;
  logic [ADDR_W-1:0] post;

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_inc;
  logic [DATA_W-1:0] prev;
  logic              prev_vld;

  logic arm;
  logic active;
  logic wr_go;
  logic hit_rise;
  logic hit_fall;
  logic hit_lvl;
  logic hit_auto;
  logic trig;

`ifdef AUTO_TRIG_EN
  localparam int AW = $clog2(AUTO_TIMEOUT + 1);
  logic [AW-1:0] acnt;
  logic [AW-1:0] acnt_inc;
  assign acnt_inc = acnt + 1'b1;
  assign hit_auto = (acnt_inc == AW'(AUTO_TIMEOUT));
`else
  assign hit_auto = 1'b0;
`endif

  assign active  = (state == FILL) || (state == WAIT_TRIG) ||
                   (state == POST);
  assign arm     = start && !abort &&
                   ((state == IDLE) || (state == DONE));
  assign wr_go   = bus.ad_valid && active && !abort;
  assign cnt_inc = cnt + 1'b1;

  assign hit_rise = (prev < lvl) && (bus.ad_data >= lvl);
  assign hit_fall = (prev > lvl) && (bus.ad_data <= lvl);
  assign hit_lvl  = prev_vld && (rise ? hit_rise : hit_fall);
  assign trig     = wr_go && (state == WAIT_TRIG) &&
                    (hit_lvl || hit_auto);

  assign busy = active;
  assign done = (state == DONE);

  always_ff @(posedge I_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start)
            state_n = (pre_len == '0) ? WAIT_TRIG : FILL;
        end
        FILL: begin
          if (wr_go && (cnt_inc == pre))
            state_n = WAIT_TRIG;
        end
        WAIT_TRIG: begin
          if (trig)
            state_n = (post == '0) ? DONE : POST;
        end
        POST: begin
          if (wr_go && (cnt_inc == post))
            state_n = DONE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      ptr         <= '0;
      cnt         <= '0;
      prev        <= '0;
      prev_vld    <= 1'b0;
      lvl         <= '0;
      rise        <= 1'b0;
      pre         <= '0;
      post        <= '0;
      trig_addr   <= '0;
      start_addr  <= '0;
    end else begin
      bus.wr_en <= wr_go;
      if (wr_go) begin
        bus.wr_addr <= ptr;
        bus.wr_data <= bus.ad_data;
        ptr         <= ptr + 1'b1;
        prev        <= bus.ad_data;
        prev_vld    <= 1'b1;
        if (state == WAIT_TRIG) cnt <= '0;
        else                    cnt <= cnt_inc;
      end
      // Config is frozen at arm so the running record is self-consistent
      if (arm) begin
        lvl      <= trig_level;
        rise     <= trig_rise;
        pre      <= pre_len;
        post     <= post_len;
        cnt      <= '0;
        prev_vld <= 1'b0;
      end
      if (trig) begin
        trig_addr  <= ptr;
        start_addr <= ptr - pre;
      end
    end
  end

`ifdef AUTO_TRIG_EN
  always_ff @(posedge I_clk or negedge rst_n) begin
    if (!rst_n) begin
      acnt      <= '0;
      auto_trig <= 1'b0;
    end else if (abort || arm) begin
      acnt      <= '0;
      auto_trig <= 1'b0;
    end else begin
      if (wr_go && (state == WAIT_TRIG))
        acnt <= acnt_inc;
      if (trig)
        auto_trig <= !hit_lvl;
    end
  end
`endif

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed scoreboard bench for adc_capture_ctrl.
// Build with +define+AUTO_TRIG_EN to cover the forced-trigger path.
module tb_adc_capture_ctrl;

  localparam int DW = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [DW-1:0] trig_level;
  logic          trig_rise;
  logic [AW-1:0] pre_len;
  logic [AW-1:0] post_len;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] start_addr;
`ifdef AUTO_TRIG_EN
  logic          auto_trig;
`endif

  adc_capture_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  adc_capture_ctrl #(
    .DATA_W(DW),
    .ADDR_W(AW)
`ifdef AUTO_TRIG_EN
    ,
    .AUTO_TIMEOUT(8)
`endif
  ) dut (
    .I_clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .bus(bus.slave),
    .trig_level(trig_level),
    .trig_rise(trig_rise),
    .pre_len(pre_len),
    .post_len(post_len),
    .busy(busy),
    .done(done),
    .trig_addr(trig_addr),
    .start_addr(start_addr)
`ifdef AUTO_TRIG_EN
    ,
    .auto_trig(auto_trig)
`endif
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW-1:0] ptr = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every observed RAM write must match the next expected one
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.wr_en === 1'b1) begin
      logic [AW+DW-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL extra_write: got addr %0d data %0h want none",
                 bus.wr_addr, bus.wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({bus.wr_addr, bus.wr_data} !== e) begin
          errs++;
          $display("FAIL write: got addr %0d data %0h want addr %0d data %0h",
                   bus.wr_addr, bus.wr_data, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit w);
    bus.ad_valid = 1'b1;
    bus.ad_data  = d;
    if (w) begin
      exp_q.push_back({ptr, d});
      ptr = ptr + 1'b1;
    end
    tick();
    bus.ad_valid = 1'b0;
  endtask

  task automatic arm(input int pre, input int post, input bit r,
                     input logic [DW-1:0] lvl);
    pre_len    = AW'(pre);
    post_len   = AW'(post);
    trig_rise  = r;
    trig_level = lvl;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    trig_level = '0;
    trig_rise = 1'b1;
    pre_len = '0;
    post_len = '0;
    bus.ad_valid = 1'b0;
    bus.ad_data = '0;

    // reset with samples streaming
    for (int i = 0; i < 4; i++) send(8'(i + 1), 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) send(8'hAA, 1'b0);
    chk("rst_outputs",
        {bus.wr_en, bus.wr_addr, bus.wr_data, busy, done,
         trig_addr, start_addr}, '0);

    // rising ramp, pre 4 post 3; later input changes must not matter
    arm(4, 3, 1'b1, 8'h80);
    pre_len = '0;
    trig_level = 8'h10;
    for (int i = 1; i <= 7; i++) send(8'(i * 16), 1'b1);
    chk("ramp_wait_busy", {30'd0, busy, done}, 32'd2);
    send(8'h80, 1'b1);
    chk("ramp_trig_addr", trig_addr, 32'd7);
    chk("ramp_start_addr", start_addr, 32'd3);
    send(8'h90, 1'b1);
    send(8'hA0, 1'b1);
    chk("ramp_post_busy", {30'd0, busy, done}, 32'd2);
    send(8'hB0, 1'b1);
    chk("ramp_done", {30'd0, busy, done}, 32'd1);
    send(8'hC0, 1'b0);
    send(8'hD0, 1'b0);
    chk("ramp_done_hold", {30'd0, busy, done}, 32'd1);

    // walk the pointer to 1022, then abort from WAIT_TRIG
    arm(1011, 1, 1'b1, 8'hFF);
    for (int i = 0; i < 1011; i++) send(8'(i), 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("walk_abort", {30'd0, busy, done}, 32'd0);

    // wrap across DEPTH-1 -> 0
    arm(3, 1, 1'b1, 8'h80);
    send(8'h00, 1'b1);
    send(8'h00, 1'b1);
    send(8'h00, 1'b1);
    send(8'h90, 1'b1);
    chk("wrap_trig_addr", trig_addr, 32'd1);
    chk("wrap_start_addr", start_addr, 32'd1022);
    send(8'h11, 1'b1);
    chk("wrap_done", {30'd0, busy, done}, 32'd1);

    // falling, first-sample rule, pre 0
    arm(0, 2, 1'b0, 8'h40);
    trig_level = 8'h00;
    send(8'h30, 1'b1);
    send(8'h30, 1'b1);
    send(8'h50, 1'b1);
    chk("fall_no_trig", {30'd0, busy, done}, 32'd2);
    send(8'h40, 1'b1);
    chk("fall_trig_addr", trig_addr, 32'd6);
    chk("fall_start_addr", start_addr, 32'd6);
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    chk("fall_done", {30'd0, busy, done}, 32'd1);

    // abort with start during POST, then clean re-arm
    arm(0, 5, 1'b1, 8'h80);
    send(8'h00, 1'b1);
    send(8'h90, 1'b1);
    send(8'h91, 1'b1);
    start = 1'b1;
    abort = 1'b1;
    send(8'h92, 1'b0);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_idle", {29'd0, bus.wr_en, busy, done}, 32'd0);
    send(8'h93, 1'b0);
    send(8'h94, 1'b0);
    chk("abort_stays", {30'd0, busy, done}, 32'd0);
    arm(2, 1, 1'b1, 8'h80);
    send(8'h00, 1'b1);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    chk("rearm_trig_addr", trig_addr, 32'd14);
    chk("rearm_start_addr", start_addr, 32'd12);
    send(8'h33, 1'b1);
    chk("rearm_done", {30'd0, busy, done}, 32'd1);

`ifdef AUTO_TRIG_EN
    arm(0, 2, 1'b1, 8'h80);
    for (int i = 0; i < 7; i++) send(8'h00, 1'b1);
    chk("auto_pending", {30'd0, busy, auto_trig}, 32'd2);
    send(8'h00, 1'b1);
    chk("auto_trig_flag", {31'd0, auto_trig}, 32'd1);
    chk("auto_trig_addr", trig_addr, 32'd23);
    chk("auto_start_addr", start_addr, 32'd23);
    send(8'h00, 1'b1);
    send(8'h00, 1'b1);
    chk("auto_done", {30'd0, busy, done}, 32'd1);
    arm(1, 1, 1'b1, 8'h80);
    chk("auto_clear_on_arm", {31'd0, auto_trig}, 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`endif

    tick();
    tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Sequences capture of 8-bit ADC samples into a circular sample RAM with pre-trigger and post-trigger windows. Replaces free-running write toggling with an armed, level/edge-qualified trigger in the I_clk domain. Sits between the ADC sample path and the dual-port capture RAM. Reports trigger and start addresses so readout logic can unwrap the record.

Parameters:
DATA_W, 8, sample width
ADDR_W, 10, RAM address width; DEPTH = 2^ADDR_W
AUTO_TIMEOUT, 65535, sample strobes in WAIT_TRIG before forced trigger (AUTO_TRIG_EN only)

Ports:
I_clk  input  1  system clock; all logic rising-edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse; arm a capture
abort  input  1  one-cycle pulse; cancel capture
ad_valid  input  1  sample strobe, one cycle per sample
ad_data  input  DATA_W  ADC sample, valid with ad_valid
trig_level  input  DATA_W  trigger threshold, unsigned
trig_rise  input  1  1 = rising-edge trigger, 0 = falling-edge trigger
pre_len  input  ADDR_W  pre-trigger samples required before trigger is accepted
post_len  input  ADDR_W  samples written after the trigger sample
wr_en  output  1  RAM write strobe
wr_addr  output  ADDR_W  RAM write address
wr_data  output  DATA_W  RAM write data
busy  output  1  high in FILL, WAIT_TRIG, POST
done  output  1  record complete; level signal
trig_addr  output  ADDR_W  address of the trigger sample
start_addr  output  ADDR_W  trig_addr - pre_len, modulo DEPTH

Behaviour:
- Reset: state=IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, trig_addr=0, start_addr=0; internal counters and the prev-sample flag are cleared.
- States: IDLE, FILL, WAIT_TRIG, POST, DONE.
- IDLE/DONE + start -> FILL. If pre_len=0, go directly to WAIT_TRIG. Arming clears done, sets the pre-count to 0 and clears prev_valid. wr_addr is not reset on arm; the buffer continues from its current pointer.
- start is ignored while busy.
- abort in any state -> IDLE on the next edge; done=0; no further wr_en. If start and abort arrive in the same cycle, abort wins.
- Write path: in FILL, WAIT_TRIG and POST, ad_valid at cycle t gives wr_en=1 at t+1 for exactly one cycle, with wr_data equal to the sample at t and wr_addr equal to the current pointer. The pointer increments after each write and wraps from DEPTH-1 to 0. wr_en=0 in IDLE and DONE.
- FILL: counts written samples. When the count reaches pre_len, go to WAIT_TRIG. Trigger evaluation is not performed in FILL.
- Trigger detection (WAIT_TRIG, on each ad_valid):
  - Rising: prev < trig_level AND cur >= trig_level.
  - Falling: prev > trig_level AND cur <= trig_level.
  - prev = last sample seen with ad_valid since arming. It tracks through FILL. The first sample after arming never triggers (prev_valid=0).
- On trigger at cycle t: the trigger sample is written normally at t+1. trig_addr and start_addr are latched at t+1. State moves to POST at t+1. If post_len=0, state moves to DONE instead.
- POST: counts samples written after the trigger sample. When the count equals post_len, the final write occurs, and on that same t+1 edge state=DONE and done=1.
- Overlap: the caller guarantees pre_len+post_len+1 <= DEPTH. If violated, the oldest pre-trigger samples are overwritten; there is no error flag.
- trig_level, trig_rise, pre_len and post_len are sampled at arm and held internally; later changes have no effect on the running capture.
- ad_valid on consecutive cycles must be supported at full rate.

Optional Feature:
AUTO_TRIG_EN:
- Defined: in WAIT_TRIG, ad_valid strobes are counted without a trigger. On the AUTO_TIMEOUT-th strobe, that sample is treated as the trigger, identically to a real trigger.
- An extra output, auto_trig (1 bit), is set with trig_addr and cleared on arm, abort and reset.
- Not defined: WAIT_TRIG waits indefinitely; no auto_trig port exists.

Test Plan:
- Reset with a sample stream running -> all outputs 0; no wr_en until start.
- pre_len=4, post_len=3, rising, level=0x80. Ramp 0x10,0x20,...; ad_valid every cycle -> 4 FILL writes. Trigger on the first sample >=0x80 whose prev is <0x80. trig_addr = address of that write; start_addr = trig_addr-4. Exactly 3 more writes, then done=1 and no more wr_en.
- Pointer at 1022 (ADDR_W=10), 5 writes -> addresses 1022,1023,0,1,2. With pre_len=3 and trigger at addr 1, start_addr=1022.
- Falling, level=0x40, first armed sample 0x30 then 0x30 -> no trigger (first-sample rule; no crossing). Then 0x50,0x40 -> trigger on 0x40.
- abort during POST, asserted together with start -> IDLE next cycle; done=0; wr_en=0 thereafter. A later start re-arms normally.
- AUTO_TRIG_EN with AUTO_TIMEOUT=8 and a flat input of 0x00 -> trigger on the 8th WAIT_TRIG strobe; auto_trig=1; post_len writes follow, then done=1.
